// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer between EX/MEM and the dcache, with LR/SC reservation tracking.
// Define MISALIGN_CHK_EN to trap misaligned halfword/word accesses instead of issuing them.
module mem_access_ctrl #(
    parameter int WORD_W = 32,
    parameter int CPUID  = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dREN_i,
    input  logic              dWEN_i,
    input  logic              atomic_i,
    input  logic [2:0]        func3_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] store_i,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [3:0]        dmembe,
    output logic              mem_stall,
    output logic              mem_ack,
    output logic [WORD_W-1:0] load_data,
    output logic              misalign
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [WORD_W-1:0]   r_addr;
    logic [2:0]          r_func3;
    logic                r_isStore;
    logic                r_isSc;
    logic                r_isLr;
    logic                r_misalign;
    logic [WORD_W-1:0]   r_store;
    logic [3:0]          r_be;
    logic                r_resvValid;
    logic [WORD_W-1:2]   r_resvAddr;

    logic                w_req;
    logic                w_isSc;
    logic                w_isLr;
    logic [1:0]          w_size;
    logic                w_misalign;
    logic                w_snoopHitResv;
    logic                w_scPass;
    logic [WORD_W-1:0]   w_storeMerge;
    logic [3:0]          w_beMerge;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [WORD_W-1:0]   w_loadExt;
    logic                w_unused;

    if (CPUID < 0) begin : g_cpuidRange
    end

    assign w_req    = dREN_i | dWEN_i;
    assign w_isSc   = dWEN_i & atomic_i;
    assign w_isLr   = dREN_i & ~dWEN_i & atomic_i;
    assign w_size   = atomic_i ? 2'b10 : func3_i[1:0];
    assign w_unused = &{1'b0, snoop_addr[1:0]};

`ifdef MISALIGN_CHK_EN
    assign w_misalign = ((w_size == 2'b01) & addr_i[0]) |
                        ((w_size == 2'b10) & (addr_i[1:0] != 2'b00));
    assign misalign   = (r_state == DONE) & r_misalign;
`else
    assign w_misalign = 1'b0;
    assign misalign   = 1'b0;
`endif

    // A snoop in the same cycle as SC evaluation kills the reservation before it is consulted
    assign w_snoopHitResv = snoop_inv & (snoop_addr[WORD_W-1:2] == r_resvAddr);
    assign w_scPass       = r_resvValid & (addr_i[WORD_W-1:2] == r_resvAddr) & ~w_snoopHitResv;

    always_comb begin
        w_storeMerge = store_i;
        w_beMerge    = 4'b1111;
        case (w_size)
            2'b00: begin
                w_storeMerge = {(WORD_W/8){store_i[7:0]}};
                w_beMerge    = 4'b0001 << addr_i[1:0];
            end
            2'b01: begin
                w_storeMerge = {(WORD_W/16){store_i[15:0]}};
                w_beMerge    = 4'b0011 << {addr_i[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign w_byte = dmemload[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = dmemload[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_loadExt = dmemload;
        case (r_func3)
            3'b000:  w_loadExt = {{(WORD_W-8){w_byte[7]}}, w_byte};
            3'b001:  w_loadExt = {{(WORD_W-16){w_half[15]}}, w_half};
            3'b100:  w_loadExt = {{(WORD_W-8){1'b0}}, w_byte};
            3'b101:  w_loadExt = {{(WORD_W-16){1'b0}}, w_half};
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        mem_stall   = 1'b0;
        mem_ack     = 1'b0;
        dmemREN     = 1'b0;
        dmemWEN     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    mem_stall = 1'b1;
                    if (w_misalign || (w_isSc && !w_scPass)) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextState = REQ;
                    end
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                dmemREN   = ~r_isStore;
                dmemWEN   = r_isStore;
                if (dhit) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                mem_ack     = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr     <= '0;
            r_func3    <= '0;
            r_isStore  <= 1'b0;
            r_isSc     <= 1'b0;
            r_isLr     <= 1'b0;
            r_misalign <= 1'b0;
            r_store    <= '0;
            r_be       <= '0;
            load_data  <= '0;
        end else begin
            if (r_state == IDLE && w_req) begin
                r_addr     <= addr_i;
                r_func3    <= atomic_i ? 3'b010 : func3_i;
                r_isStore  <= dWEN_i;
                r_isSc     <= w_isSc;
                r_isLr     <= w_isLr;
                r_misalign <= w_misalign;
                r_store    <= w_storeMerge;
                r_be       <= w_beMerge;
                if (w_misalign) begin
                    load_data <= '0;
                end else if (w_isSc && !w_scPass) begin
                    load_data <= {{(WORD_W-1){1'b0}}, 1'b1};
                end
            end else if (r_state == REQ && dhit) begin
                load_data <= r_isStore ? '0 : w_loadExt;
            end
        end
    end

    // Later assignments win: a matching snoop overrides any set from an LR completing this cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_resvValid <= 1'b0;
            r_resvAddr  <= '0;
        end else begin
            if (r_state == REQ && dhit && r_isLr) begin
                r_resvValid <= ~(snoop_inv & (snoop_addr[WORD_W-1:2] == r_addr[WORD_W-1:2]));
                r_resvAddr  <= r_addr[WORD_W-1:2];
            end else begin
                if (r_state == REQ && dhit && r_isStore && !r_isSc &&
                    r_addr[WORD_W-1:2] == r_resvAddr) begin
                    r_resvValid <= 1'b0;
                end
                if (r_state == DONE && r_isSc && !r_misalign) begin
                    r_resvValid <= 1'b0;
                end
                if (w_snoopHitResv) begin
                    r_resvValid <= 1'b0;
                end
            end
        end
    end

    assign dmemaddr  = {r_addr[WORD_W-1:2], 2'b00};
    assign dmemstore = r_store;
    assign dmembe    = r_be;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: loads, stores, LR/SC, snoops, reset mid-access.
module tb_mem_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        dREN = 1'b0, dWEN = 1'b0, atomic = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] addr = '0, store = '0;
    logic        dhit = 1'b0;
    logic [31:0] dmemload = '0;
    logic        snoopInv = 1'b0;
    logic [31:0] snoopAddr = '0;

    logic        dmemREN, dmemWEN, mem_stall, mem_ack, misalign;
    logic [31:0] dmemaddr, dmemstore, load_data;
    logic [3:0]  dmembe;

    int compared   = 0;
    int mismatched = 0;

    logic        stallIdle, sawRen, sawWen, gotAck, ackMis;
    logic [31:0] reqAddr, reqStore, ackLoad;
    logic [3:0]  reqBe;
    int          ackCycle, reqCycles;

    mem_access_ctrl #(.WORD_W(32), .CPUID(0)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .dREN_i     (dREN),
        .dWEN_i     (dWEN),
        .atomic_i   (atomic),
        .func3_i    (func3),
        .addr_i     (addr),
        .store_i    (store),
        .dhit       (dhit),
        .dmemload   (dmemload),
        .snoop_inv  (snoopInv),
        .snoop_addr (snoopAddr),
        .dmemREN    (dmemREN),
        .dmemWEN    (dmemWEN),
        .dmemaddr   (dmemaddr),
        .dmemstore  (dmemstore),
        .dmembe     (dmembe),
        .mem_stall  (mem_stall),
        .mem_ack    (mem_ack),
        .load_data  (load_data),
        .misalign   (misalign)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one request as the EX/MEM latch would, answers it like a dcache after
    // 'delay' REQ cycles, and records what was seen up to the acknowledge.
    task automatic applyStimulus(input logic ren, input logic wen, input logic atom,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] st, input logic [31:0] ld,
                                 input int delay, input logic snp);
        @(posedge CLK); #1;
        dREN = ren; dWEN = wen; atomic = atom; func3 = f3; addr = a; store = st;
        snoopInv = snp; snoopAddr = a;
        @(negedge CLK);
        stallIdle = mem_stall;
        sawRen = 1'b0; sawWen = 1'b0; gotAck = 1'b0; ackMis = 1'b0;
        reqAddr = '0; reqStore = '0; reqBe = '0; ackLoad = '0;
        ackCycle = 0; reqCycles = 0;
        for (int c = 0; c < 20 && !gotAck; c++) begin
            @(posedge CLK); #1;
            dhit = 1'b0;
            snoopInv = 1'b0;
            if (dmemREN || dmemWEN) begin
                sawRen   = sawRen | dmemREN;
                sawWen   = sawWen | dmemWEN;
                reqAddr  = dmemaddr;
                reqStore = dmemstore;
                reqBe    = dmembe;
                if (reqCycles == delay) begin
                    dhit = 1'b1;
                    dmemload = ld;
                end
                reqCycles++;
            end
            @(negedge CLK);
            if (mem_ack) begin
                gotAck   = 1'b1;
                ackCycle = c + 1;
                ackLoad  = load_data;
                ackMis   = misalign;
            end
        end
        dREN = 1'b0; dWEN = 1'b0; atomic = 1'b0; dhit = 1'b0;
    endtask

    initial begin
        logic [2:0]  lf3 [6];
        logic [31:0] laddr [6];
        logic [31:0] lload [6];
        logic [31:0] lexp [6];
        lf3   = '{3'b101, 3'b001, 3'b100, 3'b000, 3'b001, 3'b010};
        laddr = '{32'h102, 32'h102, 32'h101, 32'h100, 32'h100, 32'h008};
        lload = '{32'h8765_4321, 32'h8765_4321, 32'h0000_A500, 32'h0000_007F,
                  32'h0000_ABCD, 32'hDEAD_BEEF};
        lexp  = '{32'h0000_8765, 32'hFFFF_8765, 32'h0000_00A5, 32'h0000_007F,
                  32'hFFFF_ABCD, 32'hDEAD_BEEF};

        repeat (2) @(negedge CLK);
        checkOutput("rst_dmemREN", dmemREN, 0);
        checkOutput("rst_dmemWEN", dmemWEN, 0);
        checkOutput("rst_dmemaddr", dmemaddr, 0);
        checkOutput("rst_dmemstore", dmemstore, 0);
        checkOutput("rst_dmembe", dmembe, 0);
        checkOutput("rst_mem_stall", mem_stall, 0);
        checkOutput("rst_mem_ack", mem_ack, 0);
        checkOutput("rst_load_data", load_data, 0);
        checkOutput("rst_misalign", misalign, 0);
        #1 RST = 1'b0;

        $display("[TB] LB sign-extend, dhit in second REQ cycle");
        applyStimulus(1, 0, 0, 3'b000, 32'h103, 0, 32'h80FF_FF00, 1, 0);
        checkOutput("lb_stall_idle", stallIdle, 1);
        checkOutput("lb_ren", sawRen, 1);
        checkOutput("lb_wen", sawWen, 0);
        checkOutput("lb_addr", reqAddr, 32'h100);
        checkOutput("lb_ack", gotAck, 1);
        checkOutput("lb_ack_cycle", ackCycle, 3);
        checkOutput("lb_data", ackLoad, 32'hFFFF_FF80);

        $display("[TB] load extension table, dhit in first REQ cycle");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 0, lf3[i], laddr[i], 0, lload[i], 0, 0);
            checkOutput($sformatf("load%0d_ack_cycle", i), ackCycle, 2);
            checkOutput($sformatf("load%0d_data", i), ackLoad, lexp[i]);
        end

        $display("[TB] stores");
        applyStimulus(0, 1, 0, 3'b001, 32'h202, 32'h1234, 0, 0, 0);
        checkOutput("sh_wen", sawWen, 1);
        checkOutput("sh_ren", sawRen, 0);
        checkOutput("sh_addr", reqAddr, 32'h200);
        checkOutput("sh_store", reqStore, 32'h1234_1234);
        checkOutput("sh_be", reqBe, 4'b1100);
        applyStimulus(0, 1, 0, 3'b000, 32'h201, 32'h0000_00AB, 0, 0, 0);
        checkOutput("sb_store", reqStore, 32'hABAB_ABAB);
        checkOutput("sb_be", reqBe, 4'b0010);
        applyStimulus(1, 1, 0, 3'b010, 32'h20C, 32'hCAFE_F00D, 0, 0, 0);
        checkOutput("sw_both_wen", sawWen, 1);
        checkOutput("sw_both_ren", sawRen, 0);
        checkOutput("sw_addr", reqAddr, 32'h20C);
        checkOutput("sw_store", reqStore, 32'hCAFE_F00D);
        checkOutput("sw_be", reqBe, 4'b1111);

        $display("[TB] LR then SC pass, repeated SC fails");
        applyStimulus(1, 0, 1, 3'b010, 32'h400, 0, 32'h1111_2222, 0, 0);
        checkOutput("lr_data", ackLoad, 32'h1111_2222);
        applyStimulus(0, 1, 1, 3'b010, 32'h400, 32'h55, 0, 0, 0);
        checkOutput("sc1_wen", sawWen, 1);
        checkOutput("sc1_store", reqStore, 32'h55);
        checkOutput("sc1_ack", gotAck, 1);
        checkOutput("sc1_result", ackLoad, 0);
        applyStimulus(0, 1, 1, 3'b010, 32'h400, 32'h66, 0, 0, 0);
        checkOutput("sc2_wen", sawWen, 0);
        checkOutput("sc2_ack_cycle", ackCycle, 1);
        checkOutput("sc2_result", ackLoad, 1);

        $display("[TB] snoop in idle kills reservation");
        applyStimulus(1, 0, 1, 3'b010, 32'h400, 0, 32'h0, 0, 0);
        @(posedge CLK); #1;
        snoopInv = 1'b1; snoopAddr = 32'h402;
        @(posedge CLK); #1;
        snoopInv = 1'b0;
        applyStimulus(0, 1, 1, 3'b010, 32'h400, 32'h77, 0, 0, 0);
        checkOutput("snp_sc_wen", sawWen, 0);
        checkOutput("snp_sc_result", ackLoad, 1);

        $display("[TB] snoop same cycle as SC evaluation");
        applyStimulus(1, 0, 1, 3'b010, 32'h400, 0, 32'h0, 0, 0);
        applyStimulus(0, 1, 1, 3'b010, 32'h400, 32'h88, 0, 0, 1);
        checkOutput("snpsc_wen", sawWen, 0);
        checkOutput("snpsc_result", ackLoad, 1);

        $display("[TB] own plain store to reserved word");
        applyStimulus(1, 0, 1, 3'b010, 32'h400, 0, 32'h0, 0, 0);
        applyStimulus(0, 1, 0, 3'b010, 32'h400, 32'h99, 0, 0, 0);
        applyStimulus(0, 1, 1, 3'b010, 32'h400, 32'hAA, 0, 0, 0);
        checkOutput("st_sc_wen", sawWen, 0);
        checkOutput("st_sc_result", ackLoad, 1);

        $display("[TB] SC to other address fails and consumes reservation");
        applyStimulus(1, 0, 1, 3'b010, 32'h500, 0, 32'h0, 0, 0);
        applyStimulus(0, 1, 1, 3'b010, 32'h504, 32'h1, 0, 0, 0);
        checkOutput("scmis_result", ackLoad, 1);
        applyStimulus(0, 1, 1, 3'b010, 32'h500, 32'h2, 0, 0, 0);
        checkOutput("scafter_wen", sawWen, 0);
        checkOutput("scafter_result", ackLoad, 1);

        $display("[TB] unrelated traffic keeps reservation");
        applyStimulus(1, 0, 1, 3'b010, 32'h600, 0, 32'h0, 0, 0);
        applyStimulus(1, 0, 0, 3'b010, 32'h010, 0, 32'h5, 0, 0);
        applyStimulus(0, 1, 0, 3'b010, 32'h604, 32'h3, 0, 0, 0);
        applyStimulus(0, 1, 1, 3'b010, 32'h600, 32'h4, 0, 2, 0);
        checkOutput("keep_sc_wen", sawWen, 1);
        checkOutput("keep_sc_ack_cycle", ackCycle, 4);
        checkOutput("keep_sc_result", ackLoad, 0);

        $display("[TB] reset during REQ");
        applyStimulus(1, 0, 1, 3'b010, 32'h400, 0, 32'h0, 0, 0);
        @(posedge CLK); #1;
        dREN = 1'b1; func3 = 3'b010; addr = 32'h10;
        @(posedge CLK); #1;
        @(negedge CLK);
        checkOutput("rstreq_pre_ren", dmemREN, 1);
        #1 RST = 1'b1; dREN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("rstreq_ren", dmemREN, 0);
        checkOutput("rstreq_stall", mem_stall, 0);
        checkOutput("rstreq_ack", mem_ack, 0);
        checkOutput("rstreq_addr", dmemaddr, 0);
        RST = 1'b0;
        applyStimulus(0, 1, 1, 3'b010, 32'h400, 32'h5, 0, 0, 0);
        checkOutput("rstreq_sc_wen", sawWen, 0);
        checkOutput("rstreq_sc_result", ackLoad, 1);

        $display("[TB] misaligned LW");
`ifdef MISALIGN_CHK_EN
        applyStimulus(1, 0, 0, 3'b010, 32'h6, 0, 32'h1357_2468, 0, 0);
        checkOutput("mis_ren", sawRen, 0);
        checkOutput("mis_ack_cycle", ackCycle, 1);
        checkOutput("mis_flag", ackMis, 1);
        checkOutput("mis_data", ackLoad, 0);
`else
        applyStimulus(1, 0, 0, 3'b010, 32'h6, 0, 32'h1357_2468, 0, 0);
        checkOutput("mis_ren", sawRen, 1);
        checkOutput("mis_addr", reqAddr, 32'h4);
        checkOutput("mis_flag", ackMis, 0);
        checkOutput("mis_data", ackLoad, 32'h1357_2468);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
